owire_arbiter: RTL and testbench

Arbiter for the shared 1-Wire master in the thermostat design. It grants exclusive use of the master's command, CRC-enable and FIFO-request inputs to one of two requesters: the protocol engine (P) or the device engine (D). Without it these inputs are simply ORed together. The arbiter muxes only the owner's signals to the master, holds ownership until any in-flight command completes, flags illegal drive from the non-owner, and can optionally revoke an owner that sits idle.

---
 rtl/owire_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_owire_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/owire_arbiter.sv
// ============================================================================
// Module   : owire_arbiter
// Purpose  : Two-requester ownership arbiter for the shared 1-Wire master.
//            Optional idle-owner revoke enabled by macro OWIRE_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module owire_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_req,
  output logic       p_gnt,
  input  logic [2:0] p_cmd,
  input  logic       p_crc8,
  input  logic       p_crc16,
  input  logic       p_rdreq,
  input  logic       p_wrreq,
  input  logic       d_req,
  output logic       d_gnt,
  input  logic [2:0] d_cmd,
  input  logic       d_crc8,
  input  logic       d_crc16,
  input  logic       d_rdreq,
  input  logic       d_wrreq,
  output logic [2:0] m_cmd,
  output logic       m_crc8,
  output logic       m_crc16,
  output logic       m_rdreq,
  output logic       m_wrreq,
  input  logic       ow_done,
  input  logic       err_clr,
  output logic       conflict,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_P = 2'd1,
    S_OWN_D = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_inflight;
  logic   w_inflight_nxt;
  logic   r_last_p;
  logic   w_last_p_nxt;
  logic   r_conflict;
  logic   r_timeout;
  logic   w_issue;
  logic   w_p_drive;
  logic   w_d_drive;
  logic   w_violation;
  logic   w_revoke;
  logic   w_cnt_hit;
  logic   w_p_elig;
  logic   w_d_elig;

  always_comb begin
    p_gnt   = (r_state == S_OWN_P);
    d_gnt   = (r_state == S_OWN_D);
    m_cmd   = 3'd0;
    m_crc8  = 1'b0;
    m_crc16 = 1'b0;
    m_rdreq = 1'b0;
    m_wrreq = 1'b0;
    if (r_state == S_OWN_P) begin
      m_cmd   = p_cmd;
      m_crc8  = p_crc8;
      m_crc16 = p_crc16;
      m_rdreq = p_rdreq;
      m_wrreq = p_wrreq;
    end else if (r_state == S_OWN_D) begin
      m_cmd   = d_cmd;
      m_crc8  = d_crc8;
      m_crc16 = d_crc16;
      m_rdreq = d_rdreq;
      m_wrreq = d_wrreq;
    end
  end

  assign w_issue        = |m_cmd;
  // Issuing a new command outranks a completion arriving in the same cycle.
  assign w_inflight_nxt = w_issue | (r_inflight & ~ow_done);
  assign w_p_drive      = (|p_cmd) | p_crc8 | p_crc16 | p_rdreq | p_wrreq;
  assign w_d_drive      = (|d_cmd) | d_crc8 | d_crc16 | d_rdreq | d_wrreq;
  assign w_violation    = (w_p_drive & ~p_gnt) | (w_d_drive & ~d_gnt);

`ifdef OWIRE_ARB_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_idle_cnt;
  logic               r_block_p;
  logic               r_block_d;
  logic               w_owning;

  assign w_owning  = p_gnt | d_gnt;
  assign w_cnt_hit = w_owning & ~r_inflight & ~w_issue & ~ow_done &
                     (r_idle_cnt == c_CNT_LAST);
  assign w_p_elig  = p_req & ~r_block_p;
  assign w_d_elig  = d_req & ~r_block_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_block_p  <= 1'b0;
      r_block_d  <= 1'b0;
    end else begin
      if (!w_owning || w_issue || ow_done || w_cnt_hit)
        r_idle_cnt <= '0;
      else if (!r_inflight)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      // A revoked requester must drop req for a cycle before it is eligible again.
      if (w_revoke && p_gnt)
        r_block_p <= 1'b1;
      else if (!p_req)
        r_block_p <= 1'b0;
      if (w_revoke && d_gnt)
        r_block_d <= 1'b1;
      else if (!d_req)
        r_block_d <= 1'b0;
    end
  end
`else
  localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_cnt_hit = 1'b0;
  assign w_p_elig  = p_req;
  assign w_d_elig  = d_req;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_last_p_nxt = r_last_p;
    w_revoke     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_p_elig && w_d_elig) begin
          w_state_nxt  = r_last_p ? S_OWN_D : S_OWN_P;
          w_last_p_nxt = ~r_last_p;
        end else if (w_p_elig) begin
          w_state_nxt  = S_OWN_P;
          w_last_p_nxt = 1'b1;
        end else if (w_d_elig) begin
          w_state_nxt  = S_OWN_D;
          w_last_p_nxt = 1'b0;
        end
      end
      S_OWN_P: begin
        if (!p_req) begin
          w_state_nxt = w_inflight_nxt ? S_DRAIN : S_IDLE;
        end else if (w_cnt_hit) begin
          w_state_nxt = S_IDLE;
          w_revoke    = 1'b1;
        end
      end
      S_OWN_D: begin
        if (!d_req) begin
          w_state_nxt = w_inflight_nxt ? S_DRAIN : S_IDLE;
        end else if (w_cnt_hit) begin
          w_state_nxt = S_IDLE;
          w_revoke    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ow_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_last_p   <= 1'b0;
      r_conflict <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      r_last_p   <= w_last_p_nxt;
      if (w_violation)  r_conflict <= 1'b1;
      else if (err_clr) r_conflict <= 1'b0;
      if (w_revoke)     r_timeout  <= 1'b1;
      else if (err_clr) r_timeout  <= 1'b0;
    end
  end

  assign conflict = r_conflict;
  assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_owire_arbiter.sv
// ============================================================================
// Module   : tb_owire_arbiter
// Purpose  : Directed + random self-checking bench for owire_arbiter against
//            an ownership-level reference model (honours OWIRE_ARB_TIMEOUT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_owire_arbiter;

  localparam int TO = 16;
`ifdef OWIRE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       p_req, p_gnt, p_crc8, p_crc16, p_rdreq, p_wrreq;
  logic       d_req, d_gnt, d_crc8, d_crc16, d_rdreq, d_wrreq;
  logic [2:0] p_cmd, d_cmd, m_cmd;
  logic       m_crc8, m_crc16, m_rdreq, m_wrreq;
  logic       ow_done, err_clr, conflict, timeout;

  always #5 clk = ~clk;

  owire_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_gnt(p_gnt), .p_cmd(p_cmd), .p_crc8(p_crc8),
    .p_crc16(p_crc16), .p_rdreq(p_rdreq), .p_wrreq(p_wrreq),
    .d_req(d_req), .d_gnt(d_gnt), .d_cmd(d_cmd), .d_crc8(d_crc8),
    .d_crc16(d_crc16), .d_rdreq(d_rdreq), .d_wrreq(d_wrreq),
    .m_cmd(m_cmd), .m_crc8(m_crc8), .m_crc16(m_crc16),
    .m_rdreq(m_rdreq), .m_wrreq(m_wrreq),
    .ow_done(ow_done), .err_clr(err_clr),
    .conflict(conflict), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = P, 2 = D, 3 = draining.
  int m_owner, m_cnt;
  bit m_infl, m_last_p, m_conf, m_tmo, m_blk_p, m_blk_d;

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_infl = 0; m_last_p = 0;
    m_conf = 0; m_tmo = 0; m_blk_p = 0; m_blk_d = 0;
  endtask

  task automatic check_outputs();
    logic [2:0] ecmd;
    logic [3:0] estr;
    ecmd = (m_owner == 1) ? p_cmd : (m_owner == 2) ? d_cmd : 3'd0;
    estr = (m_owner == 1) ? {p_crc8, p_crc16, p_rdreq, p_wrreq} :
           (m_owner == 2) ? {d_crc8, d_crc16, d_rdreq, d_wrreq} : 4'd0;
    check("p_gnt",    p_gnt, m_owner == 1);
    check("d_gnt",    d_gnt, m_owner == 2);
    check("m_cmd",    m_cmd, ecmd);
    check("m_strobe", {m_crc8, m_crc16, m_rdreq, m_wrreq}, estr);
    check("conflict", conflict, m_conf);
    check("timeout",  timeout, m_tmo);
  endtask

  task automatic model_step();
    bit issued, pdrv, ddrv, viol, nin, pok, dok, oreq, revoke;
    int nxt;
    if (reset) begin
      model_reset();
      return;
    end
    issued = (m_owner == 1 && p_cmd != 0) || (m_owner == 2 && d_cmd != 0);
    pdrv   = (p_cmd != 0) || p_crc8 || p_crc16 || p_rdreq || p_wrreq;
    ddrv   = (d_cmd != 0) || d_crc8 || d_crc16 || d_rdreq || d_wrreq;
    viol   = (pdrv && m_owner != 1) || (ddrv && m_owner != 2);
    nin    = issued || (m_infl && !ow_done);
    revoke = 0;
    nxt    = m_owner;
    case (m_owner)
      0: begin
        pok = p_req && !m_blk_p;
        dok = d_req && !m_blk_d;
        if (pok && dok) nxt = m_last_p ? 2 : 1;
        else if (pok)   nxt = 1;
        else if (dok)   nxt = 2;
        if (nxt != 0) m_last_p = (nxt == 1);
        m_cnt = 0;
      end
      1, 2: begin
        oreq = (m_owner == 1) ? p_req : d_req;
        if (issued || ow_done) m_cnt = 0;
        else if (!m_infl)      m_cnt++;
        if (!oreq) begin
          nxt   = nin ? 3 : 0;
          m_cnt = 0;
        end else if (TO_EN && m_cnt >= TO) begin
          revoke = 1;
          nxt    = 0;
          m_cnt  = 0;
          if (m_owner == 1) m_blk_p = 1; else m_blk_d = 1;
        end
      end
      default: if (ow_done) nxt = 0;
    endcase
    if (!p_req) m_blk_p = 0;
    if (!d_req) m_blk_d = 0;
    m_conf  = viol ? 1'b1 : (err_clr ? 1'b0 : m_conf);
    m_tmo   = revoke ? 1'b1 : (err_clr ? 1'b0 : m_tmo);
    m_infl  = nin;
    m_owner = nxt;
  endtask

  // Inputs are set #1 after posedge; outputs are sampled 3 ns later.
  task automatic step();
    #3;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    p_cmd = 0; {p_crc8, p_crc16, p_rdreq, p_wrreq} = 4'd0;
    d_cmd = 0; {d_crc8, d_crc16, d_rdreq, d_wrreq} = 4'd0;
    ow_done = 0; err_clr = 0; reset = 0;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 15) == 0) p_req = ~p_req;
    if ($urandom_range(0, 15) == 0) d_req = ~d_req;
    p_cmd = 0; {p_crc8, p_crc16, p_rdreq, p_wrreq} = 4'd0;
    d_cmd = 0; {d_crc8, d_crc16, d_rdreq, d_wrreq} = 4'd0;
    if (m_owner == 1 || $urandom_range(0, 63) == 0) begin
      if ($urandom_range(0, 5) == 0) p_cmd = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) {p_crc8, p_crc16, p_rdreq, p_wrreq} = 4'($urandom);
    end
    if (m_owner == 2 || $urandom_range(0, 63) == 0) begin
      if ($urandom_range(0, 5) == 0) d_cmd = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) {d_crc8, d_crc16, d_rdreq, d_wrreq} = 4'($urandom);
    end
    ow_done = m_infl ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
    err_clr = ($urandom_range(0, 19) == 0);
    reset   = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    p_req = 0; d_req = 0;
    quiet();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    step();                          // reset state
    reset = 0;

    // Single requester with one command
    p_req = 1; step();
    step();
    p_cmd = 3'd2; step();
    p_cmd = 0; ow_done = 1; step();
    ow_done = 0; p_req = 0; step();
    step();

    // Tie after reset ordering, then round robin
    p_req = 1; d_req = 1; step();
    repeat (3) step();
    p_req = 0; repeat (3) step();
    p_req = 1; repeat (2) step();
    d_req = 0; repeat (3) step();
    p_req = 0; step();
    p_req = 1; d_req = 1; repeat (3) step();
    p_req = 0; d_req = 0; repeat (2) step();

    // Drain: D issues then drops req, completion 50 cycles later
    d_req = 1; repeat (2) step();
    d_cmd = 3'd1; step();
    d_cmd = 0; d_req = 0; p_req = 1;
    repeat (50) step();
    ow_done = 1; step();
    ow_done = 0; repeat (3) step();

    // Conflict while P owns, clear, then clear racing a new violation
    d_cmd = 3'd4; p_cmd = 3'd3; step();
    d_cmd = 0; p_cmd = 0; ow_done = 1; step();
    ow_done = 0; err_clr = 1; step();
    d_crc8 = 1; step();
    d_crc8 = 0; err_clr = 0; step();
    err_clr = 1; step();
    err_clr = 0; p_req = 0; repeat (2) step();

    // Idle owner (revoked when the timeout feature is built in)
    p_req = 1; repeat (TO + 3) step();
    d_req = 1; repeat (6) step();
    d_req = 0; repeat (4) step();
    p_req = 0; step();
    p_req = 1; repeat (3) step();
    p_req = 0; err_clr = 1; step();
    err_clr = 0;

    // Reset while D owns with a command in flight
    d_req = 1; repeat (2) step();
    d_cmd = 3'd2; step();
    d_cmd = 0; reset = 1; step();
    reset = 0; d_req = 0; ow_done = 1; step();
    ow_done = 0; step();

    // Random traffic
    p_req = 0; d_req = 0;
    repeat (4000) begin
      rand_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
